// File: rtl/mac_feeder_pkg.sv
// Shared types and helpers for the mac_feeder operand sequencer.
// Optional build macro used by this slice: MAC_FEEDER_SQDIFF_EN.
package mac_feeder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Flat element index of lane 'lane' within chunk 'chunk'.
  function automatic int unsigned elem_index(input int unsigned chunk,
                                             input int unsigned concat,
                                             input int unsigned lane);
    return chunk * concat + lane;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/mac_feeder_lane_prep.sv
// One lane of operand preparation: zero masking plus, when MAC_FEEDER_SQDIFF_EN
// is defined, the saturated difference a-b fed to both MAC operands.
module mac_feeder_lane_prep
  import mac_feeder_pkg::*;
#(
  parameter int IN_WIDTH = 16
) (
  input  logic                       en,
  input  logic signed [IN_WIDTH-1:0] a,
  input  logic signed [IN_WIDTH-1:0] b,
  output logic signed [IN_WIDTH-1:0] out_1,
  output logic signed [IN_WIDTH-1:0] out_2
);

`ifdef MAC_FEEDER_SQDIFF_EN
  localparam logic signed [IN_WIDTH:0] SAT_HI = (IN_WIDTH+1)'(sat_max(IN_WIDTH));
  localparam logic signed [IN_WIDTH:0] SAT_LO = (IN_WIDTH+1)'(sat_min(IN_WIDTH));

  function automatic logic signed [IN_WIDTH-1:0] sat(input logic signed [IN_WIDTH:0] x);
    if (x > SAT_HI)      return SAT_HI[IN_WIDTH-1:0];
    else if (x < SAT_LO) return SAT_LO[IN_WIDTH-1:0];
    else                 return x[IN_WIDTH-1:0];
  endfunction

  logic signed [IN_WIDTH:0]   diff;
  logic signed [IN_WIDTH-1:0] d;

  assign diff  = {a[IN_WIDTH-1], a} - {b[IN_WIDTH-1], b};
  assign d     = en ? sat(diff) : '0;
  assign out_1 = d;
  assign out_2 = d;
`else
  assign out_1 = en ? a : '0;
  assign out_2 = en ? b : '0;
`endif

endmodule

// File: rtl/mac_feeder.sv
// Streams two operand vectors from synchronous-read memories into the CONCAT-lane
// MAC and returns the accumulated result over valid/ready (MAC_FEEDER_SQDIFF_EN: squared distance).
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int CONCAT     = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           start_ready,
  input  logic [ADDR_WIDTH-1:0]          base_a,
  input  logic [ADDR_WIDTH-1:0]          base_b,
  input  logic [LEN_WIDTH-1:0]           len,
  output logic                           rd_en,
  output logic [ADDR_WIDTH-1:0]          addr_a,
  output logic [ADDR_WIDTH-1:0]          addr_b,
  input  logic [CONCAT*IN_WIDTH-1:0]     rd_data_a,
  input  logic [CONCAT*IN_WIDTH-1:0]     rd_data_b,
  output logic [CONCAT*IN_WIDTH-1:0]     mac_in_1,
  output logic [CONCAT*IN_WIDTH-1:0]     mac_in_2,
  output logic                           mac_in_valid,
  output logic                           mac_reset,
  input  logic                           mac_out_valid,
  input  logic signed [2*IN_WIDTH-1:0]   mac_out,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [2*IN_WIDTH-1:0]   res_data,
  output logic                           busy
);

  localparam int DW = CONCAT * IN_WIDTH;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   base_a_q, base_b_q;
  logic [LEN_WIDTH-1:0]    len_q, n_chunks, issue_cnt, out_cnt;
  logic [LEN_WIDTH:0]      n_chunks_w;
  logic                    accept, last_issue, collecting, capture;
  logic                    vld_p0;
  logic [LEN_WIDTH-1:0]    chunk_p0;
  logic [CONCAT-1:0]       lane_en;
  logic [DW-1:0]           prep_1, prep_2;

  assign accept     = start && (state == IDLE);
  assign n_chunks_w = ({1'b0, len} + (LEN_WIDTH+1)'(CONCAT - 1)) / (LEN_WIDTH+1)'(CONCAT);
  assign last_issue = (issue_cnt == n_chunks - 1'b1);
  assign collecting = (state == RUN) || (state == DRAIN);
  assign capture    = collecting && mac_out_valid && (out_cnt == n_chunks - 1'b1);

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign res_valid   = (state == DONE);
  assign rd_en       = (state == RUN);
  assign addr_a      = rd_en ? base_a_q + ADDR_WIDTH'(issue_cnt) : '0;
  assign addr_b      = rd_en ? base_b_q + ADDR_WIDTH'(issue_cnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)     state_n = (len == '0) ? DONE : RUN;
      RUN:     if (last_issue) state_n = DRAIN;
      DRAIN:   if (capture)    state_n = DONE;
      DONE:    if (res_ready)  state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  // Job parameters and the chunk tag riding with the read are pure data.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_a_q <= base_a;
      base_b_q <= base_b;
      len_q    <= len;
    end
    chunk_p0 <= issue_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_chunks     <= '0;
      issue_cnt    <= '0;
      out_cnt      <= '0;
      vld_p0       <= 1'b0;
      mac_in_valid <= 1'b0;
      mac_reset    <= 1'b0;
      mac_in_1     <= '0;
      mac_in_2     <= '0;
      res_data     <= '0;
    end else begin
      if (accept) begin
        n_chunks  <= n_chunks_w[LEN_WIDTH-1:0];
        issue_cnt <= '0;
        out_cnt   <= '0;
        if (len == '0) res_data <= '0;
      end
      if (rd_en) issue_cnt <= issue_cnt + 1'b1;
      if (collecting && mac_out_valid) out_cnt <= out_cnt + 1'b1;
      if (capture) res_data <= mac_out;
      // p0: memory returns the word issued last cycle
      vld_p0 <= rd_en;
      // p1: masked/prepared operands presented to the MAC
      mac_in_valid <= vld_p0;
      mac_reset    <= vld_p0 && (chunk_p0 == '0);
      mac_in_1     <= vld_p0 ? prep_1 : '0;
      mac_in_2     <= vld_p0 ? prep_2 : '0;
    end
  end

  always_comb begin
    lane_en = '0;
    for (int k = 0; k < CONCAT; k++)
      lane_en[k] = elem_index(32'(chunk_p0), CONCAT, k) < 32'(len_q);
  end

  for (genvar k = 0; k < CONCAT; k++) begin : g_lane
    mac_feeder_lane_prep #(.IN_WIDTH(IN_WIDTH)) u_prep (
      .en    (lane_en[k]),
      .a     (rd_data_a[k*IN_WIDTH +: IN_WIDTH]),
      .b     (rd_data_b[k*IN_WIDTH +: IN_WIDTH]),
      .out_1 (prep_1[k*IN_WIDTH +: IN_WIDTH]),
      .out_2 (prep_2[k*IN_WIDTH +: IN_WIDTH])
    );
  end

endmodule
